// File: rtl/fifo_reader.sv
// Read-side drain controller: pulses rd_en, captures the FIFO word, hands it to a valid/ready sink.
// Optional WAIT timeout enabled by defining FIFO_READER_TIMEOUT_EN.
module fifo_reader #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 8,
   parameter int unsigned TIMEOUT    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  empty,
   input  logic                  rd_ack,
   input  logic                  rd_err,
   input  logic [DATA_WIDTH-1:0] d_in,
   output logic                  rd_en,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   input  logic                  err_clr,
   output logic                  err,
   output logic [3:0]            err_cnt,
   output logic [CNT_WIDTH-1:0]  rd_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'b000,
      ST_READ  = 3'b001,
      ST_WAIT  = 3'b010,
      ST_OUT   = 3'b011,
      ST_ERROR = 3'b100
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  w_take;
   logic                  w_deliver;
   logic                  w_timeout;

   logic                  r_rd_en;
   logic                  r_m_valid;
   logic [DATA_WIDTH-1:0] r_m_data;
   logic                  r_err;
   logic [3:0]            r_err_cnt;
   logic [CNT_WIDTH-1:0]  r_rd_cnt;

`ifdef FIFO_READER_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   logic [TW-1:0] r_to_cnt;

   // Cleared while in READ so every WAIT visit starts counting from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_to_cnt <= '0;
      else if (r_state == ST_READ)
         r_to_cnt <= '0;
      else if (r_state == ST_WAIT)
         r_to_cnt <= r_to_cnt + 1'b1;
   end

   assign w_timeout = (r_state == ST_WAIT) && !rd_ack && (r_to_cnt == TW'(TIMEOUT - 1));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT == 0);
   assign w_timeout        = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_take    = 1'b0;
      w_deliver = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (enable && !empty)
               w_next = ST_READ;
         end
         ST_READ: begin
            w_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (rd_err || w_timeout) begin
               w_next = ST_ERROR;
            end else if (rd_ack) begin
               w_take = 1'b1;
               w_next = ST_OUT;
            end
         end
         ST_OUT: begin
            if (m_ready) begin
               w_deliver = 1'b1;
               w_next    = (enable && !empty) ? ST_READ : ST_IDLE;
            end
         end
         ST_ERROR: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // rd_en is registered from the next state so it is high exactly during READ.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_en   <= 1'b0;
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
         r_rd_cnt  <= '0;
      end else begin
         r_rd_en <= (w_next == ST_READ);
         if (w_take) begin
            r_m_valid <= 1'b1;
            r_m_data  <= d_in;
         end else if (w_deliver) begin
            r_m_valid <= 1'b0;
         end
         if (w_deliver)
            r_rd_cnt <= r_rd_cnt + 1'b1;
         if (err_clr) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
         end else if (r_state == ST_ERROR) begin
            r_err <= 1'b1;
            if (r_err_cnt != 4'hF)
               r_err_cnt <= r_err_cnt + 1'b1;
         end
      end
   end

   assign rd_en   = r_rd_en;
   assign m_valid = r_m_valid;
   assign m_data  = r_m_data;
   assign err     = r_err;
   assign err_cnt = r_err_cnt;
   assign rd_cnt  = r_rd_cnt;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a small FIFO responder driven from the step task.
// Define FIFO_READER_TIMEOUT_EN for both files to exercise the WAIT timeout.
module tb_fifo_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        empty;
   logic        rd_ack;
   logic        rd_err;
   logic [31:0] d_in;
   logic        rd_en;
   logic        m_valid;
   logic [31:0] m_data;
   logic        m_ready;
   logic        err_clr;
   logic        err;
   logic [3:0]  err_cnt;
   logic [7:0]  rd_cnt;

   always #5 clk = ~clk;

   fifo_reader #(
      .DATA_WIDTH(32),
      .CNT_WIDTH (8),
      .TIMEOUT   (4)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .empty  (empty),
      .rd_ack (rd_ack),
      .rd_err (rd_err),
      .d_in   (d_in),
      .rd_en  (rd_en),
      .m_valid(m_valid),
      .m_data (m_data),
      .m_ready(m_ready),
      .err_clr(err_clr),
      .err    (err),
      .err_cnt(err_cnt),
      .rd_cnt (rd_cnt)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc      = 0;
   int          mode     = 0;   // 0 ack, 1 err, 2 ack+err, 3 silent
   bit          mv_seen  = 1'b0;
   logic [31:0] fifo_q[$];
   logic [31:0] got_q[$];
   int          rden_cyc[$];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One clock: record what the DUT presents, cross the edge, then answer a pending read.
   task automatic step();
      bit pend;
      pend = rd_en;
      if (m_valid && m_ready) got_q.push_back(m_data);
      if (m_valid) mv_seen = 1'b1;
      if (rd_en) rden_cyc.push_back(cyc);
      @(posedge clk);
      #1;
      cyc++;
      rd_ack = 1'b0;
      rd_err = 1'b0;
      if (pend) begin
         case (mode)
            0: begin
               rd_ack = 1'b1;
               if (fifo_q.size() > 0) d_in = fifo_q.pop_front();
               else d_in = 32'hDEAD_DEAD;
            end
            1: rd_err = 1'b1;
            2: begin
               rd_ack = 1'b1;
               rd_err = 1'b1;
               d_in   = 32'hBAD0_BAD0;
            end
            default: ;
         endcase
      end
      empty = (fifo_q.size() == 0);
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      enable  = 1'b0;
      m_ready = 1'b0;
      err_clr = 1'b0;
      rd_ack  = 1'b0;
      rd_err  = 1'b0;
      d_in    = '0;
      mode    = 0;
      fifo_q.delete();
      empty   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      got_q.delete();
      rden_cyc.delete();
      mv_seen = 1'b0;
   endtask

   task automatic do_err(input int md, input bit clr);
      mode   = md;
      enable = 1'b1;
      step();
      enable = 1'b0;
      step();
      step();
      err_clr = clr;
      step();
      err_clr = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int bad;

      do_reset();
      chk("rst_rd_en", rd_en, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_err", err, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_rd_cnt", rd_cnt, 0);

      rd_ack = 1'b1;
      d_in   = 32'h1234;
      step();
      chk("idle_ack_ignored", m_valid, 0);

      // Single word
      fifo_q.push_back(32'hA5A5_0001);
      empty   = 1'b0;
      enable  = 1'b1;
      m_ready = 1'b1;
      step();
      chk("t1_rd_en_pulse", rd_en, 1);
      step();
      chk("t1_rd_en_single", rd_en, 0);
      chk("t1_no_early_valid", m_valid, 0);
      step();
      chk("t1_m_valid", m_valid, 1);
      chk("t1_m_data", m_data, 32'hA5A5_0001);
      step();
      chk("t1_valid_clr", m_valid, 0);
      chk("t1_rd_cnt", rd_cnt, 1);
      chk("t1_rden_count", rden_cyc.size(), 1);
      chk("t1_delivered", got_q.size(), 1);

      // Burst of eight
      do_reset();
      for (int i = 1; i <= 8; i++) fifo_q.push_back(32'(i));
      empty   = 1'b0;
      enable  = 1'b1;
      m_ready = 1'b1;
      repeat (30) step();
      chk("t2_rden_count", rden_cyc.size(), 8);
      bad = 0;
      for (int i = 1; i < rden_cyc.size(); i++)
         if (rden_cyc[i] - rden_cyc[i-1] != 3) bad++;
      chk("t2_spacing", bad, 0);
      chk("t2_delivered", got_q.size(), 8);
      bad = 0;
      for (int i = 0; i < got_q.size(); i++)
         if (got_q[i] !== 32'(i + 1)) bad++;
      chk("t2_order", bad, 0);
      chk("t2_rd_cnt", rd_cnt, 8);
      chk("t2_idle_rd_en", rd_en, 0);
      chk("t2_idle_valid", m_valid, 0);

      // Backpressure
      do_reset();
      fifo_q.push_back(32'hBEEF_0003);
      fifo_q.push_back(32'hBEEF_0004);
      empty   = 1'b0;
      enable  = 1'b1;
      m_ready = 1'b0;
      repeat (3) step();
      chk("t3_valid", m_valid, 1);
      bad = 0;
      repeat (5) begin
         step();
         if (!m_valid || m_data !== 32'hBEEF_0003 || rd_en) bad++;
      end
      chk("t3_hold", bad, 0);
      chk("t3_rd_cnt_held", rd_cnt, 0);
      m_ready = 1'b1;
      enable  = 1'b0;
      step();
      chk("t3_delivered", got_q.size(), 1);
      if (got_q.size() > 0) chk("t3_word", got_q[0], 32'hBEEF_0003);
      chk("t3_rd_cnt", rd_cnt, 1);
      chk("t3_valid_clr", m_valid, 0);
      chk("t3_rden_count", rden_cyc.size(), 1);

      // Read errors, saturation, clear
      do_reset();
      fifo_q.push_back(32'h5555_5555);
      empty = 1'b0;
      do_err(1, 1'b0);
      chk("t4_err", err, 1);
      chk("t4_err_cnt1", err_cnt, 1);
      do_err(2, 1'b0);
      chk("t4_err_cnt2", err_cnt, 2);
      chk("t4_no_valid", m_valid, 0);
      chk("t4_never_valid", mv_seen, 0);
      repeat (13) do_err(1, 1'b0);
      chk("t4_err_cnt15", err_cnt, 15);
      repeat (2) do_err(1, 1'b0);
      chk("t4_saturate", err_cnt, 15);
      chk("t4_err_sticky", err, 1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("t4_clr_err", err, 0);
      chk("t4_clr_cnt", err_cnt, 0);
      do_err(1, 1'b0);
      chk("t4_recount", err_cnt, 1);
      do_err(1, 1'b1);
      chk("t4_clr_wins_cnt", err_cnt, 0);
      chk("t4_clr_wins_err", err, 0);

      // Reset while in OUT
      do_reset();
      fifo_q.push_back(32'h11);
      fifo_q.push_back(32'h22);
      empty   = 1'b0;
      enable  = 1'b1;
      m_ready = 1'b1;
      repeat (4) step();
      chk("t5_rd_cnt_pre", rd_cnt, 1);
      m_ready = 1'b0;
      repeat (2) step();
      chk("t5_in_out", m_valid, 1);
      chk("t5_data_pre", m_data, 32'h22);
      #2;
      reset = 1'b1;
      #1;
      chk("t5_async_valid", m_valid, 0);
      chk("t5_async_rd_cnt", rd_cnt, 0);
      chk("t5_async_data", m_data, 0);

      // Silent FIFO
      do_reset();
      mode = 3;
      fifo_q.push_back(32'h77);
      empty  = 1'b0;
      enable = 1'b1;
      step();
      enable = 1'b0;
`ifdef FIFO_READER_TIMEOUT_EN
      repeat (4) step();
      chk("t6_no_early_err", err_cnt, 0);
      step();
      chk("t6_in_error", err, 0);
      step();
      chk("t6_timeout_err", err, 1);
      chk("t6_timeout_cnt", err_cnt, 1);
`else
      bad = 0;
      repeat (20) begin
         step();
         if (err || rd_en || m_valid) bad++;
      end
      chk("t6_wait_hold", bad, 0);
      rd_ack = 1'b1;
      d_in   = 32'h77;
      step();
      chk("t6_late_ack_valid", m_valid, 1);
      chk("t6_late_ack_data", m_data, 32'h77);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side drain controller for the team's 8-entry handshake FIFO. It watches the FIFO's `empty` flag, issues single-cycle `rd_en` pulses, captures the returned word on `rd_ack`, and presents it to a downstream valid/ready sink. It also counts delivered words and FIFO read errors. It sits between the FIFO's read port and the consuming datapath, as the counterpart to the FIFO's write-side driver.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: FIFO word width.
- `CNT_WIDTH`, default 8: width of the delivered-word counter.
- `TIMEOUT`, default 4: cycles allowed in WAIT before a forced error. Used only with `FIFO_READER_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  permits new FIFO reads.
- `empty`  in  1  FIFO empty flag.
- `rd_ack`  in  1  FIFO read acknowledge; valid the cycle after `rd_en`.
- `rd_err`  in  1  FIFO read error (read while empty).
- `d_in`  in  DATA_WIDTH  FIFO read data; valid with `rd_ack`.
- `rd_en`  out  1  FIFO read request, one-cycle pulse.
- `m_valid`  out  1  output word valid.
- `m_data`  out  DATA_WIDTH  output word.
- `m_ready`  in  1  downstream accepts `m_data`.
- `err_clr`  in  1  synchronous clear of the error status.
- `err`  out  1  sticky error flag.
- `err_cnt`  out  4  saturating count of read errors.
- `rd_cnt`  out  CNT_WIDTH  count of words delivered downstream, wraps.

## Operation
- FSM, 3-bit encoding: IDLE=000, READ=001, WAIT=010, OUT=011, ERROR=100.
- **IDLE:** `rd_en`=0. Moves to READ if `enable && !empty`; otherwise stays in IDLE.
- **READ:** `rd_en`=1 for exactly this cycle, then always moves to WAIT.
- **WAIT:** `rd_en`=0.
  - `rd_err`=1: go to ERROR. `rd_err` wins if `rd_ack` is high in the same cycle; the data is discarded.
  - `rd_ack`=1 only: load `m_data` from `d_in`, set `m_valid`=1, go to OUT.
  - Neither: stay in WAIT.
- **OUT:** `m_valid`=1 and `m_data` are held stable until `m_ready`=1. On a cycle with `m_valid && m_ready`:
  - `rd_cnt` increments, wrapping 2^CNT_WIDTH−1 to 0.
  - `m_valid` clears.
  - Next state is READ if `enable && !empty`, else IDLE.
- **ERROR:** set `err`=1 and increment `err_cnt`, saturating at 15. Return to IDLE after one cycle.
- `err_clr`=1 clears `err` and `err_cnt` on the next edge, in any state. If an increment is due in the same cycle, the clear wins.
- Deasserting `enable` never aborts a transaction. An in-flight READ, WAIT or OUT completes; only new reads are suppressed.
- `rd_ack` or `rd_err` arriving in IDLE, READ, OUT or ERROR is ignored.
- At most one outstanding FIFO read at any time.

## Timing
- Reset values: state=IDLE, `rd_en`=0, `m_valid`=0, `m_data`=0, `err`=0, `err_cnt`=0, `rd_cnt`=0.
- Asserting `reset` mid-transaction clears all outputs immediately. Any pending or captured word is lost.
- FIFO latency:
  - `rd_en` high in cycle N.
  - `rd_ack` or `rd_err` sampled from cycle N+1.
  - `m_valid` high from cycle N+2.
- Sustained throughput with `m_ready` tied high and the FIFO non-empty: one word per 3 cycles (READ→WAIT→OUT→READ).
- `empty` is sampled only in IDLE and in the OUT handoff cycle.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `FIFO_READER_TIMEOUT_EN` defined:
  - A counter runs while in WAIT.
  - After `TIMEOUT` consecutive WAIT cycles with neither `rd_ack` nor `rd_err`, the FSM goes to ERROR, counted like `rd_err`.
  - The counter resets on entry to WAIT.
- Not defined: WAIT holds indefinitely, and no timeout logic is synthesised.

## Test plan
- Reset, then `enable`=1 with `empty`=0. FIFO returns `rd_ack` with `d_in`=32'hA5A5_0001 one cycle after `rd_en`, and `m_ready`=1. Required: `rd_en` pulses once, `m_valid` is high 2 cycles after `rd_en` with `m_data`=32'hA5A5_0001, and `rd_cnt`=1.
- Preload 8 words 1..8 and hold `m_ready`=1. Required: 8 `rd_en` pulses spaced 3 cycles apart, output order 1..8, `rd_cnt`=8, then IDLE once `empty`=1.
- Backpressure: `m_ready`=0 for 5 cycles while in OUT. Required: `m_data` stable, no `rd_en` issued, and the word is delivered on the first `m_ready`=1 cycle.
- Respond to `rd_en` with `rd_err`, and separately with `rd_ack` and `rd_err` together. Required: `err`=1 and `err_cnt`=1, then 2. `m_valid` never asserts.
- Errors and clear:
  - Force 17 errors. Required: `err_cnt` saturates at 15.
  - Assert `err_clr`. Required: `err`=0 and `err_cnt`=0 next cycle.
  - Assert `reset` in OUT. Required: `m_valid`=0 immediately and `rd_cnt`=0.
- With `FIFO_READER_TIMEOUT_EN` and `TIMEOUT`=4, the FIFO never responds. Required: ERROR is entered after 4 WAIT cycles and `err_cnt`=1. Without the macro, the FSM stays in WAIT for at least 20 cycles.
